// File: rtl/calc_pkg.sv
// Key-code map and edit-state encoding shared by the expression edit buffer.
package calc_pkg;

  localparam int N_TOKENS = 23;
  localparam int K_LEFT   = 23;
  localparam int K_RIGHT  = 24;
  localparam int K_BKSP   = 25;
  localparam int K_CLR    = 26;

  typedef enum logic [1:0] {S_IDLE, S_INS, S_DEL, S_CLR} edit_state_t;

  function automatic logic is_token(input int code);
    return (code >= 0) && (code < N_TOKENS);
  endfunction

endpackage

// File: rtl/edit_buffer.sv
// Expression edit buffer: key events -> character cells, fill size and cursor,
// with a one-cell-per-cycle shift engine for insert, backspace and clear.
module edit_buffer
  import calc_pkg::*;
#(
  parameter int buttons = 27,
  parameter int depth   = 32,
  parameter int width   = 8,
  localparam int KW = $clog2(buttons),
  localparam int SW = $clog2(depth + 1),
  localparam int IW = $clog2(depth)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          key_valid,
  input  logic [KW-1:0]                 key_code,
  output logic                          key_ready,
  output logic [depth-1:0][width-1:0]   mem,
  output logic [SW-1:0]                 size_out,
  output logic [SW-1:0]                 ptr_out,
  output logic                          err_full,
  output logic                          changed
);

  localparam logic [SW-1:0] ONE_S  = SW'(1);
  localparam logic [IW-1:0] ONE_I  = IW'(1);
  localparam logic [SW-1:0] FULL   = SW'(depth);
  localparam logic [IW-1:0] LAST_I = IW'(depth - 1);

  edit_state_t               state, state_d;
  logic [IW-1:0]             idx, idx_d;
  logic [width-1:0]          tok, tok_d, tok_in;
  logic [SW-1:0]             size, size_d, ptr, ptr_d;
  logic [depth-1:0][width-1:0] mem_d;
  logic                      chg_d, err_d, accept, tail_ok;

  assign key_ready = (state == S_IDLE);
  assign accept    = key_valid && key_ready && (int'(key_code) < buttons);
  assign tok_in    = width'(key_code) + width'(1);
  assign size_out  = size;
  assign ptr_out   = ptr;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    tok_d   = tok;
    size_d  = size;
    ptr_d   = ptr;
    mem_d   = mem;
    chg_d   = 1'b0;
    err_d   = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        if (is_token(int'(key_code))) begin
          if (size == FULL) begin
            err_d = 1'b1;
          end else if (ptr == size) begin
            mem_d[IW'(ptr)] = tok_in;
            size_d = size + ONE_S;
            ptr_d  = ptr + ONE_S;
            chg_d  = 1'b1;
          end else begin
            tok_d   = tok_in;
            idx_d   = IW'(size);
            state_d = S_INS;
          end
        end else if (key_code == KW'(K_LEFT)) begin
          if (ptr != '0) begin
            ptr_d = ptr - ONE_S;
            chg_d = 1'b1;
          end
        end else if (key_code == KW'(K_RIGHT)) begin
          if (ptr < size) begin
            ptr_d = ptr + ONE_S;
            chg_d = 1'b1;
          end
        end else if (key_code == KW'(K_BKSP)) begin
          if (ptr != '0) begin
            idx_d   = IW'(ptr - ONE_S);
            state_d = S_DEL;
          end
        end else if (key_code == KW'(K_CLR)) begin
          idx_d   = '0;
          state_d = S_CLR;
        end
      end
      // Open a hole at the cursor by moving the tail up one cell per cycle.
      S_INS: begin
        if (SW'(idx) > ptr) begin
          mem_d[idx] = mem[idx - ONE_I];
          idx_d      = idx - ONE_I;
        end else begin
          mem_d[idx] = tok;
          size_d     = size + ONE_S;
          ptr_d      = ptr + ONE_S;
          chg_d      = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_DEL: begin
        if (SW'(idx) < size - ONE_S) begin
          mem_d[idx] = mem[idx + ONE_I];
          idx_d      = idx + ONE_I;
        end else begin
          mem_d[idx] = '0;
          size_d     = size - ONE_S;
          ptr_d      = ptr - ONE_S;
          chg_d      = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_CLR: begin
        mem_d[idx] = '0;
        if (idx == LAST_I) begin
          size_d  = '0;
          ptr_d   = '0;
          chg_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d = idx + ONE_I;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      tok      <= '0;
      size     <= '0;
      ptr      <= '0;
      mem      <= '0;
      changed  <= 1'b0;
      err_full <= 1'b0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      tok      <= tok_d;
      size     <= size_d;
      ptr      <= ptr_d;
      mem      <= mem_d;
      changed  <= chg_d;
      err_full <= err_d;
    end
  end

  // The tail is only guaranteed clean between operations; insert writes past size mid-shift.
  always_comb begin
    tail_ok = 1'b1;
    for (int i = 0; i < depth; i++)
      if (i >= int'(size) && mem[i] != '0) tail_ok = 1'b0;
  end

  a_invariants: assert property (@(posedge clock) disable iff (!reset)
    (ptr <= size) && (size <= FULL) && (state != S_IDLE || tail_ok));

endmodule
